// File: rtl/csr_pkg.sv
// Shared CSR address map, mstatus bit positions, mcause codes and handler state.
// Counter CSR presence is selected in csr_unit by the CSR_COUNTERS_EN macro.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MISA     = 12'h301;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE    = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
   localparam logic [11:0] CSR_INSTRET  = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH = 12'hC82;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [3:0] CAUSE_ILLEGAL_INSTR = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT    = 4'd3;
   localparam logic [3:0] CAUSE_ECALL_M       = 4'd11;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_HANDLER = 1'b1
   } csr_state_t;

   // Counter addresses stay mapped even when the counters are compiled out.
   function automatic logic csr_is_mapped(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
         CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
         CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
         CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH,
         CSR_MHARTID: csr_is_mapped = 1'b1;
         default:     csr_is_mapped = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] mstatus_pack(input logic mie_bit, input logic mpie_bit);
      logic [31:0] v;
      v = '0;
      v[MSTATUS_MIE]                   = mie_bit;
      v[MSTATUS_MPIE]                  = mpie_bit;
      v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return v;
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter built from two 32-bit halves, each independently writable.
// Writes take effect next cycle; a written half does not increment, and a write to the low half suppresses its carry.
import csr_pkg::*;

module csr_counter64 (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wr_data,
   output logic [63:0] count
);

   logic [31:0] lo_q;
   logic [31:0] hi_q;
   logic        lo_carry;

   assign lo_carry = inc & ~wr_lo & (lo_q == 32'hFFFF_FFFF);

   always_ff @(posedge clk) begin
      if (reset) begin
         lo_q <= '0;
         hi_q <= '0;
      end else begin
         if (wr_lo) begin
            lo_q <= wr_data;
         end else if (inc) begin
            lo_q <= lo_q + 32'd1;
         end
         // A high-half write wins over the carry, so that carry is dropped.
         if (wr_hi) begin
            hi_q <= wr_data;
         end else if (lo_carry) begin
            hi_q <= hi_q + 32'd1;
         end
      end
   end

   assign count = {hi_q, lo_q};

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: combinational reads, writes/traps/mret commit at posedge, no stall path.
// Define CSR_COUNTERS_EN to build mcycle/minstret and their cycle/instret shadows; otherwise they read 0.
import csr_pkg::*;

module csr_unit #(
   parameter logic [31:0] HART_ID   = 32'd0,
   parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_valid,
   input  logic [11:0] csr_addr,
   input  logic        csr_we,
   input  logic [31:0] csr_wr_data,
   output logic [31:0] csr_rd_data,
   output logic        csr_illegal,
   input  logic        instr_retire,
   input  logic        trap_req,
   input  logic [3:0]  trap_cause,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_val,
   input  logic        mret,
   output logic [31:0] trap_vector,
   output logic [31:0] epc,
   output logic        in_handler,
   output logic        double_trap
);

   csr_state_t  state;
   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic [31:0] mie_reg;
   logic [31:0] mtvec;
   logic [31:0] mscratch;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mtval;
   logic        double_trap_q;

   logic        mapped;
   logic        wr_commit;
   logic [63:0] mcycle;
   logic [63:0] minstret;
   logic [31:0] rd_data;

   assign mapped      = csr_is_mapped(csr_addr);
   assign csr_illegal = csr_valid & (~mapped | (csr_we & (csr_addr[11:10] == 2'b11)));
   // A trap in the same cycle squashes the instruction's CSR write.
   assign wr_commit   = csr_valid & csr_we & ~csr_illegal & ~trap_req;

`ifdef CSR_COUNTERS_EN
   csr_counter64 u_mcycle (
      .clk     (clk),
      .reset   (reset),
      .inc     (1'b1),
      .wr_lo   (wr_commit && (csr_addr == CSR_MCYCLE)),
      .wr_hi   (wr_commit && (csr_addr == CSR_MCYCLEH)),
      .wr_data (csr_wr_data),
      .count   (mcycle)
   );

   csr_counter64 u_minstret (
      .clk     (clk),
      .reset   (reset),
      .inc     (instr_retire & ~trap_req),
      .wr_lo   (wr_commit && (csr_addr == CSR_MINSTRET)),
      .wr_hi   (wr_commit && (csr_addr == CSR_MINSTRETH)),
      .wr_data (csr_wr_data),
      .count   (minstret)
   );
`else
   logic unused_retire;

   assign unused_retire = instr_retire;
   assign mcycle        = '0;
   assign minstret      = '0;
`endif

   always_comb begin
      rd_data = '0;
      if (csr_valid) begin
         case (csr_addr)
            CSR_MSTATUS:                 rd_data = mstatus_pack(mstatus_mie, mstatus_mpie);
            CSR_MISA:                    rd_data = MISA_VAL;
            CSR_MIE:                     rd_data = mie_reg;
            CSR_MTVEC:                   rd_data = {mtvec[31:2], 2'b00};
            CSR_MSCRATCH:                rd_data = mscratch;
            CSR_MEPC:                    rd_data = {mepc[31:2], 2'b00};
            CSR_MCAUSE:                  rd_data = mcause;
            CSR_MTVAL:                   rd_data = mtval;
            CSR_MCYCLE,   CSR_CYCLE:     rd_data = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    rd_data = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   rd_data = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rd_data = minstret[63:32];
            CSR_MHARTID:                 rd_data = HART_ID;
            default:                     rd_data = '0;
         endcase
      end
   end

   assign csr_rd_data = rd_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_RUN;
         mstatus_mie   <= 1'b0;
         mstatus_mpie  <= 1'b0;
         mie_reg       <= '0;
         mtvec         <= MTVEC_RST;
         mscratch      <= '0;
         mepc          <= '0;
         mcause        <= '0;
         mtval         <= '0;
         double_trap_q <= 1'b0;
      end else begin
         if (trap_req) begin
            mepc         <= trap_pc & ~32'd3;
            mcause       <= {28'b0, trap_cause};
            mtval        <= trap_val;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            state        <= ST_HANDLER;
            if (state == ST_HANDLER) begin
               double_trap_q <= 1'b1;
            end
         end else begin
            if (mret) begin
               mstatus_mie  <= mstatus_mpie;
               mstatus_mpie <= 1'b1;
               state        <= ST_RUN;
            end else if (wr_commit && (csr_addr == CSR_MSTATUS)) begin
               mstatus_mie  <= csr_wr_data[MSTATUS_MIE];
               mstatus_mpie <= csr_wr_data[MSTATUS_MPIE];
            end
            if (wr_commit && (csr_addr == CSR_MEPC)) begin
               mepc <= csr_wr_data & ~32'd3;
            end
            if (wr_commit && (csr_addr == CSR_MCAUSE)) begin
               mcause <= csr_wr_data;
            end
            if (wr_commit && (csr_addr == CSR_MTVAL)) begin
               mtval <= csr_wr_data;
            end
         end
         if (wr_commit && (csr_addr == CSR_MIE)) begin
            mie_reg <= csr_wr_data;
         end
         if (wr_commit && (csr_addr == CSR_MTVEC)) begin
            mtvec <= csr_wr_data;
         end
         if (wr_commit && (csr_addr == CSR_MSCRATCH)) begin
            mscratch <= csr_wr_data;
         end
      end
   end

   assign trap_vector = mtvec & ~32'd3;
   assign epc         = mepc;
   assign in_handler  = (state == ST_HANDLER);
   assign double_trap = double_trap_q;

endmodule
